// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer: routes each accepted input word to output A or B,
// each output backed by a one-entry registered stage, with saturating per-output counters.
module demux_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic a_open, b_open;
  logic acc_a, acc_b;

  // A stage can take a word if empty or draining this edge; accepts are
  // qualified by in_valid so an unknown in_sel never reaches the state.
  always_comb begin
    a_open   = !a_valid_q || a_ready;
    b_open   = !b_valid_q || b_ready;
    in_ready = in_sel ? b_open : a_open;
    acc_a    = in_valid && !in_sel && a_open;
    acc_b    = in_valid &&  in_sel && b_open;
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;

    if (a_valid_q && a_ready) a_valid_d = 1'b0;
    if (b_valid_q && b_ready) b_valid_d = 1'b0;

    if (acc_a) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
      if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
    end
    if (acc_b) begin
      b_valid_d = 1'b1;
      b_data_d  = in_data;
      if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the two output slots and saturating counters.
module tb_demux_stream;
  localparam int WIDTH   = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_valid, b_valid;
  logic             a_ready = 1'b1;
  logic             b_ready = 1'b1;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  demux_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: each output is a slot holding at most one pending word.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int ca = 0;
  int cb = 0;

  function automatic logic model_ready(input logic sel);
    if (sel) return (qb.size() == 0) || b_ready;
    return (qa.size() == 0) || a_ready;
  endfunction

  // Advance the model by one edge using the inputs currently driven, then clock.
  task automatic tick();
    logic acc;
    acc = in_valid && model_ready(in_sel);
    if (qa.size() != 0 && a_ready) void'(qa.pop_front());
    if (qb.size() != 0 && b_ready) void'(qb.pop_front());
    if (acc) begin
      if (in_sel) begin qb.push_back(in_data); if (cb < CNT_MAX) cb++; end
      else        begin qa.push_back(in_data); if (ca < CNT_MAX) ca++; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    qa.delete(); qb.delete(); ca = 0; cb = 0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_AAAA;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'hAAAA_AAAA) $display("FAIL reset_preload a_valid=%b a_data=%h exp 1/aaaaaaaa", a_valid, a_data);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (a_valid !== 1'b0 || a_data !== '0 || cnt_a !== '0) $display("FAIL reset_async a_valid=%b a_data=%h cnt_a=%0d exp 0/0/0", a_valid, a_data, cnt_a);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else pass_cnt++;
    qa.delete(); qb.delete(); ca = 0; cb = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL idle_in_ready sel=%0d got %b exp 1", s, in_ready);
      else pass_cnt++;
    end
    a_ready = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_AAAA;
    tick();
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'hAAAA_AAAA) $display("FAIL basic_a a_valid=%b a_data=%h exp 1/aaaaaaaa", a_valid, a_data);
    else pass_cnt++;
    @(negedge clk);
    in_sel = 1'b1; in_data = 32'h5555_5555;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (b_valid !== 1'b1 || b_data !== 32'h5555_5555) $display("FAIL basic_b b_valid=%b b_data=%h exp 1/55555555", b_valid, b_data);
    else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd1) $display("FAIL basic_cnt cnt_a=%0d cnt_b=%0d exp 1/1", cnt_a, cnt_b);
    else pass_cnt++;
    total_cnt++;
    if (a_valid !== 1'b0) $display("FAIL basic_a_drain a_valid=%b exp 0", a_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    a_ready = 1'b0; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_0000;
    tick();
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'h0) $display("FAIL bp_load a_valid=%b a_data=%h exp 1/00000000", a_valid, a_data);
    else pass_cnt++;
    @(negedge clk);
    in_data = 32'hFFFF_FFFF;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_blocked in_ready=%b exp 0", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'h0) $display("FAIL bp_hold a_valid=%b a_data=%h exp 1/00000000", a_valid, a_data);
    else pass_cnt++;
    @(negedge clk);
    in_sel = 1'b1; in_data = 32'hA5A5_A5A5;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_switch_ready in_ready=%b exp 1", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b_valid !== 1'b1 || b_data !== 32'hA5A5_A5A5 || a_data !== 32'h0) $display("FAIL bp_switch b=%b/%h a_data=%h exp 1/a5a5a5a5/00000000", b_valid, b_data, a_data);
    else pass_cnt++;
    @(negedge clk);
    a_ready = 1'b1; in_sel = 1'b0; in_data = 32'hFFFF_FFFF;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready in_ready=%b exp 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'hFFFF_FFFF || cnt_a !== 8'd2) $display("FAIL bp_release a=%b/%h cnt_a=%0d exp 1/ffffffff/2", a_valid, a_data, cnt_a);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 1'b0; in_data = WIDTH'(i);
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready i=%0d in_ready=%b exp 1", i, in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (a_valid !== 1'b1 || a_data !== WIDTH'(i)) $display("FAIL stream_data i=%0d a=%b/%h exp 1/%h", i, a_valid, a_data, i);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (cnt_a !== 8'd8) $display("FAIL stream_cnt cnt_a=%0d exp 8", cnt_a);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    b_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 1'b1; in_data = $urandom;
      tick();
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        total_cnt++;
        if (cnt_b !== CNT_W'(i > CNT_MAX ? CNT_MAX : i)) $display("FAIL sat_cnt_b n=%0d cnt_b=%0d exp %0d", i, cnt_b, (i > CNT_MAX ? CNT_MAX : i));
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (cnt_a !== '0 || cnt_b !== CNT_W'(cb)) $display("FAIL sat_final cnt_a=%0d cnt_b=%0d exp 0/%0d", cnt_a, cnt_b, cb);
    else pass_cnt++;
  endtask

  task automatic test_unknown_sel();
    logic [CNT_W-1:0] ca0, cb0;
    do_reset();
    @(negedge clk);
    b_ready = 1'b0; a_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDDDD_DDDD;
    tick();
    ca0 = CNT_W'(ca); cb0 = CNT_W'(cb);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_sel = 1'bx; in_data = $urandom; a_ready = 1'($urandom);
      tick();
      total_cnt++;
      if (b_valid !== 1'b1 || b_data !== 32'hDDDD_DDDD || a_valid !== 1'b0 || cnt_a !== ca0 || cnt_b !== cb0)
        $display("FAIL xsel_idle i=%0d b=%b/%h a_valid=%b cnt=%0d/%0d exp 1/dddddddd/0/%0d/%0d", i, b_valid, b_data, a_valid, cnt_a, cnt_b, ca0, cb0);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1234_5678; a_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (a_valid !== 1'b1 || a_data !== 32'h1234_5678 || b_data !== 32'hDDDD_DDDD) $display("FAIL xsel_load a=%b/%h b_data=%h exp 1/12345678/dddddddd", a_valid, a_data, b_data);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom);
      in_data  = $urandom;
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      #1;
      total_cnt++;
      if (in_ready !== model_ready(in_sel)) $display("FAIL rand_ready i=%0d in_ready=%b exp %b", i, in_ready, model_ready(in_sel));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0]))
        $display("FAIL rand_a i=%0d a=%b/%h exp %b/%h", i, a_valid, a_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : '0);
      else pass_cnt++;
      total_cnt++;
      if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0]))
        $display("FAIL rand_b i=%0d b=%b/%h exp %b/%h", i, b_valid, b_data, qb.size() != 0, (qb.size() != 0) ? qb[0] : '0);
      else pass_cnt++;
      total_cnt++;
      if (cnt_a !== CNT_W'(ca) || cnt_b !== CNT_W'(cb)) $display("FAIL rand_cnt i=%0d cnt=%0d/%0d exp %0d/%0d", i, cnt_a, cnt_b, ca, cb);
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_unknown_sel();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
